// File: rtl/bsync_sysref_sequencer_pkg.sv
// Shared definitions for the SYSREF sequencer: FSM state encoding and train modes.
// The register map imports this package too, so encodings live here only once.
package bsync_sysref_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } seq_state_e;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_GAPPED  = 2'd1;
    localparam logic [1:0] MODE_CONT    = 2'd2;
    localparam logic [1:0] MODE_RSVD    = 2'd3;

    // A train is in progress in every state except IDLE and ERROR.
    function automatic logic state_is_busy(seq_state_e s);
        return (s != ST_IDLE) && (s != ST_ERROR);
    endfunction

endpackage

// File: rtl/bsync_sysref_sequencer_sysref_phase_counter.sv
// Terminal-count timer shared by the DELAY, PULSE and GAP phases.
// While enabled it counts 0..terminal and strobes tc on the terminal cycle,
// wrapping back to 0 so back-to-back phases of equal length need no reload.
module bsync_sysref_sequencer_sysref_phase_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] terminal,
    output logic         tc
);

    logic [W-1:0] count;

    assign tc = en & ~load & (count == terminal);

    // Count while enabled; load (or reset) returns the count to zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/bsync_sysref_sequencer.sv
// SYSREF pulse-train sequencer phase-locked to the regenerated BSYNC.
// A request arms the block; the next BSYNC rising edge starts an optional delay,
// then high/low phases of bsync_ratio cycles each. Loss of BSYNC lock or a change
// in the measured ratio during a train latches a sticky error.
// Handshake: req/abort/err_clear are single-cycle strobes sampled at a clk edge;
// done/req_rejected are single-cycle registered strobes; there is no back-pressure.
module bsync_sysref_sequencer
    import bsync_sysref_sequencer_pkg::*;
#(
    parameter int RATIO_WIDTH = 16,
    parameter int COUNT_WIDTH = 8,
    parameter int DELAY_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   bsync_in,
    input  logic                   bsync_ready,
    input  logic [RATIO_WIDTH-1:0] bsync_ratio,
    input  logic                   req,
    input  logic                   abort,
    input  logic                   err_clear,
    input  logic [1:0]             mode,
    input  logic [COUNT_WIDTH-1:0] pulse_count,
    input  logic [DELAY_WIDTH-1:0] delay_cycles,
    output logic                   sysref_out,
    output logic                   busy,
    output logic                   done,
    output logic                   req_rejected,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] pulses_sent,
    output logic [STATE_W-1:0]     seq_state
);

    seq_state_e             state;
    logic                   bsync_r;
    logic                   bsync_edge;

    logic [1:0]             lat_mode;
    logic [COUNT_WIDTH-1:0] lat_count;
    logic [DELAY_WIDTH-1:0] lat_delay;
    logic [RATIO_WIDTH-1:0] lat_ratio;

    logic                   in_busy;
    logic                   err_cause;
    logic                   req_ok;
    logic                   last_pulse;
    logic [COUNT_WIDTH-1:0] pulses_next;

    logic                   ph_en;
    logic                   ph_tc;
    logic [RATIO_WIDTH-1:0] ph_term;
    logic                   dly_en;
    logic                   dly_tc;
    logic [DELAY_WIDTH-1:0] dly_term;

    assign bsync_edge  = bsync_in & ~bsync_r;
    assign in_busy     = state_is_busy(state);
    assign err_cause   = in_busy & (~bsync_ready | (bsync_ratio != lat_ratio));
    // A simultaneous abort spoils the request: it is rejected rather than accepted.
    assign req_ok      = req & ~abort & bsync_ready & (bsync_ratio != '0) & (mode != MODE_RSVD);
    assign last_pulse  = (lat_mode == MODE_ONESHOT) |
                         ((lat_mode == MODE_GAPPED) & (pulses_sent == lat_count));
    // Saturating increment keeps continuous trains from wrapping the count.
    assign pulses_next = (pulses_sent == '1) ? pulses_sent : pulses_sent + 1'b1;

    assign ph_en    = (state == ST_PULSE) || (state == ST_GAP);
    assign ph_term  = lat_ratio - 1'b1;
    assign dly_en   = (state == ST_DELAY);
    assign dly_term = lat_delay - 1'b1;

    assign busy      = in_busy;
    assign error     = (state == ST_ERROR);
    assign seq_state = state;

    bsync_sysref_sequencer_sysref_phase_counter #(.W(RATIO_WIDTH)) u_phase_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (~ph_en),
        .en       (ph_en),
        .terminal (ph_term),
        .tc       (ph_tc)
    );

    bsync_sysref_sequencer_sysref_phase_counter #(.W(DELAY_WIDTH)) u_delay_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (~dly_en),
        .en       (dly_en),
        .terminal (dly_term),
        .tc       (dly_tc)
    );

    // Register BSYNC once so its rising edge can be detected.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bsync_r <= 1'b0;
        end else begin
            bsync_r <= bsync_in;
        end
    end

    // Sequencer FSM with config latch and registered strobes; sysref_out follows
    // the PULSE state one cycle later and is dropped at once on error or abort.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            sysref_out   <= 1'b0;
            done         <= 1'b0;
            req_rejected <= 1'b0;
            pulses_sent  <= '0;
            lat_mode     <= '0;
            lat_count    <= '0;
            lat_delay    <= '0;
            lat_ratio    <= '0;
        end else begin
            sysref_out   <= 1'b0;
            done         <= 1'b0;
            req_rejected <= 1'b0;
            if (err_cause) begin
                state <= ST_ERROR;
            end else if (in_busy && abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req_ok) begin
                            lat_mode    <= mode;
                            lat_count   <= (pulse_count == '0) ? COUNT_WIDTH'(1) : pulse_count;
                            lat_delay   <= delay_cycles;
                            lat_ratio   <= bsync_ratio;
                            pulses_sent <= '0;
                            state       <= ST_ARMED;
                        end else if (req) begin
                            req_rejected <= 1'b1;
                        end
                    end
                    ST_ARMED: begin
                        if (bsync_edge) begin
                            if (lat_delay != '0) begin
                                state <= ST_DELAY;
                            end else begin
                                state       <= ST_PULSE;
                                pulses_sent <= pulses_next;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (dly_tc) begin
                            state       <= ST_PULSE;
                            pulses_sent <= pulses_next;
                        end
                    end
                    ST_PULSE: begin
                        sysref_out <= 1'b1;
                        if (ph_tc) begin
                            if (last_pulse) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_GAP;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (ph_tc) begin
                            state       <= ST_PULSE;
                            pulses_sent <= pulses_next;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    ST_ERROR: begin
                        if (err_clear) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bsync_sysref_sequencer.sv
// Bench for the SYSREF sequencer: a reference model turns each train's parameters
// into the expected SYSREF high phases and done/reject strobes; a negedge monitor
// compares what the DUT emits against those expectations.
module tb_bsync_sysref_sequencer;

    localparam int RW = 16;
    localparam int CW = 8;
    localparam int DW = 16;
    localparam int NEVER = 1 << 30;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          bsync_in = 1'b0;
    logic          bsync_ready = 1'b0;
    logic [RW-1:0] bsync_ratio = '0;
    logic          req = 1'b0;
    logic          abort = 1'b0;
    logic          err_clear = 1'b0;
    logic [1:0]    mode = '0;
    logic [CW-1:0] pulse_count = '0;
    logic [DW-1:0] delay_cycles = '0;
    logic          sysref_out;
    logic          busy;
    logic          done;
    logic          req_rejected;
    logic          error;
    logic [CW-1:0] pulses_sent;
    logic [2:0]    seq_state;

    bsync_sysref_sequencer #(.RATIO_WIDTH(RW), .COUNT_WIDTH(CW), .DELAY_WIDTH(DW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bsync_in     (bsync_in),
        .bsync_ready  (bsync_ready),
        .bsync_ratio  (bsync_ratio),
        .req          (req),
        .abort        (abort),
        .err_clear    (err_clear),
        .mode         (mode),
        .pulse_count  (pulse_count),
        .delay_cycles (delay_cycles),
        .sysref_out   (sysref_out),
        .busy         (busy),
        .done         (done),
        .req_rejected (req_rejected),
        .error        (error),
        .pulses_sent  (pulses_sent),
        .seq_state    (seq_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Expected SYSREF high phases {0, rise cycle, length} and strobes {kind, cycle, value}.
    logic [63:0] exp_pulse_q[$];
    logic [63:0] exp_evt_q[$];
    localparam logic [7:0] EV_DONE = 8'd1;
    localparam logic [7:0] EV_REJ  = 8'd2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // One train: high phase j begins (pulses_sent steps) at te+d+j*2r and is visible
    // on sysref_out from the next cycle for r cycles. Anything at or after stop is cut.
    task automatic push_train(input int te, input int d, input int r, input int md,
                              input int n, input int stop,
                              output int exp_sent, output int end_cyc);
        int np;
        int entry;
        int rise;
        int len;
        int done_c;
        np = (md == 0) ? 1 : (md == 1) ? ((n == 0) ? 1 : n) : NEVER;
        exp_sent = 0;
        end_cyc  = stop;
        for (int j = 0; j < np; j++) begin
            entry = te + d + j * 2 * r;
            if (entry >= stop) break;
            if (exp_sent < 255) exp_sent++;
            rise = entry + 1;
            if (rise < stop) begin
                len = (stop - rise < r) ? (stop - rise) : r;
                exp_pulse_q.push_back({8'd0, 32'(rise), 24'(len)});
            end
        end
        if (md != 2) begin
            done_c = te + d + r + (np - 1) * 2 * r;
            if (done_c < stop) begin
                exp_evt_q.push_back({EV_DONE, 32'(done_c), 24'(np)});
                end_cyc = done_c + 1;
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic match_pulse(input int rise, input int len);
        logic [63:0] act;
        logic [63:0] exp;
        act = {8'd0, 32'(rise), 24'(len)};
        n_checks++;
        if (exp_pulse_q.size() == 0) begin
            n_errors++;
            $display("FAIL sysref_phase: got rise=%0d len=%0d, expected none", rise, len);
        end else begin
            exp = exp_pulse_q.pop_front();
            if (exp !== act) begin
                n_errors++;
                $display("FAIL sysref_phase: got rise=%0d len=%0d, expected rise=%0d len=%0d",
                         rise, len, exp[55:24], exp[23:0]);
            end
        end
    endtask

    task automatic match_evt(input logic [7:0] kind, input int val);
        logic [63:0] act;
        logic [63:0] exp;
        act = {kind, 32'(cyc), 24'(val)};
        n_checks++;
        if (exp_evt_q.size() == 0) begin
            n_errors++;
            $display("FAIL strobe: got kind=%0d cycle=%0d val=%0d, expected none", kind, cyc, val);
        end else begin
            exp = exp_evt_q.pop_front();
            if (exp !== act) begin
                n_errors++;
                $display("FAIL strobe: got kind=%0d cycle=%0d val=%0d, expected kind=%0d cycle=%0d val=%0d",
                         kind, cyc, val, exp[63:56], exp[55:24], exp[23:0]);
            end
        end
    endtask

    bit in_run = 1'b0;
    int run_rise = 0;
    int run_len = 0;

    always @(negedge clk) begin
        if (sysref_out === 1'b1) begin
            if (!in_run) begin
                in_run   = 1'b1;
                run_rise = cyc;
                run_len  = 0;
            end
            run_len++;
        end else if (in_run) begin
            in_run = 1'b0;
            match_pulse(run_rise, run_len);
        end
        if (done === 1'b1) match_evt(EV_DONE, int'(pulses_sent));
        if (req_rejected === 1'b1) match_evt(EV_REJ, 0);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic check_queues(input string name);
        check({name, "_pulse_q_empty"}, 32'(exp_pulse_q.size()), 0);
        check({name, "_evt_q_empty"}, 32'(exp_evt_q.size()), 0);
    endtask

    task automatic arm_train(input int md, input int n, input int d, input int r, output int te);
        mode         = 2'(md);
        pulse_count  = CW'(n);
        delay_cycles = DW'(d);
        bsync_ratio  = RW'(r);
        bsync_ready  = 1'b1;
        bsync_in     = 1'b0;
        req          = 1'b1;
        tick();
        req = 1'b0;
        check("armed_state", 32'(seq_state), 1);
        repeat ($urandom_range(0, 4)) tick();
        bsync_in = 1'b1;
        te = cyc + 1;
    endtask

    // kind: 0 run to completion, 1 abort, 2 bsync_ready drop, 3 ratio change with abort, 4 reset
    task automatic run_train(input int md, input int n, input int d, input int r,
                             input int stop_off, input int kind);
        int te;
        int stop;
        int sent;
        int endc;
        arm_train(md, n, d, r, te);
        stop = (kind == 0) ? NEVER : te + stop_off;
        push_train(te, d, r, md, n, stop, sent, endc);
        if (kind == 0) begin
            wait_until(endc);
        end else begin
            wait_until(stop - 1);
            case (kind)
                1: abort = 1'b1;
                2: bsync_ready = 1'b0;
                3: begin bsync_ratio = RW'(r + 1); abort = 1'b1; end
                default: rstn = 1'b0;
            endcase
            tick();
            if (kind == 4) begin
                check("rst_sysref", 32'(sysref_out), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_error", 32'(error), 0);
                check("rst_done", 32'(done), 0);
                check("rst_pulses", 32'(pulses_sent), 0);
                check("rst_state", 32'(seq_state), 0);
                sent = 0;
            end else begin
                check("stop_sysref_low", 32'(sysref_out), 0);
            end
            abort = 1'b0;
            bsync_ready = 1'b1;
            bsync_ratio = RW'(r);
            rstn = 1'b1;
        end
        tick();
        tick();
        check("end_state", 32'(seq_state), (kind == 2 || kind == 3) ? 6 : 0);
        check("end_busy", 32'(busy), 0);
        check("end_error", 32'(error), (kind == 2 || kind == 3) ? 1 : 0);
        check("end_pulses_sent", 32'(pulses_sent), 32'(sent));
        check_queues("train");
        if (kind == 2 || kind == 3) begin
            req = 1'b1;
            tick();
            req = 1'b0;
            tick();
            check("err_req_ignored", 32'(seq_state), 6);
            err_clear = 1'b1;
            tick();
            err_clear = 1'b0;
            check("err_clear_state", 32'(seq_state), 0);
            check("err_clear_error", 32'(error), 0);
        end
    endtask

    task automatic try_reject(input logic rdy, input int md, input int r, input logic ab);
        bsync_ready = rdy;
        mode        = 2'(md);
        bsync_ratio = RW'(r);
        req         = 1'b1;
        abort       = ab;
        exp_evt_q.push_back({EV_REJ, 32'(cyc + 1), 24'd0});
        tick();
        req   = 1'b0;
        abort = 1'b0;
        check("reject_busy", 32'(busy), 0);
        check("reject_state", 32'(seq_state), 0);
        tick();
        check_queues("reject");
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int md;
        int n;
        int d;
        int r;
        int np;
        int off;
        int kind;
        rstn = 1'b0;
        repeat (3) tick();
        check("reset_sysref", 32'(sysref_out), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_rejected", 32'(req_rejected), 0);
        check("reset_error", 32'(error), 0);
        check("reset_pulses", 32'(pulses_sent), 0);
        check("reset_state", 32'(seq_state), 0);
        rstn = 1'b1;
        tick();

        run_train(0, 0, 0, 8, 0, 0);              // one-shot, ratio 8, no delay
        run_train(1, 3, 5, 4, 0, 0);              // gapped N=3, delay 5, period 8
        run_train(2, 0, 3, 4, 3 + 8 + 3, 1);      // continuous, abort in 2nd clk of 2nd high phase
        try_reject(1'b0, 0, 8, 1'b0);             // not ready
        try_reject(1'b1, 3, 8, 1'b0);             // reserved mode
        try_reject(1'b1, 1, 0, 1'b0);             // zero ratio
        try_reject(1'b1, 0, 8, 1'b1);             // req with abort
        run_train(1, 3, 2, 4, 2 + 4 + 2, 2);      // ready drops mid-GAP
        run_train(2, 0, 0, 8, 4, 3);              // ratio 8->9 with abort mid-PULSE
        run_train(1, 4, 3, 5, 3 + 10 + 3, 4);     // reset mid-train
        run_train(1, 0, 1, 1, 0, 0);              // N=0 counts as one pulse, ratio 1

        for (int t = 0; t < 12; t++) begin
            md = int'($urandom_range(0, 2));
            n  = int'($urandom_range(0, 5));
            d  = int'($urandom_range(0, 12));
            r  = int'($urandom_range(1, 10));
            np = (md == 1) ? ((n == 0) ? 1 : n) : (md == 2) ? 3 : 1;
            kind = (md == 2) ? 1 : int'($urandom_range(0, 1));
            off = int'($urandom_range(1, d + 2 * r * np + 2));
            run_train(md, n, d, r, off, kind);
        end

        repeat (3) tick();
        check_queues("final");
        check("final_no_open_phase", 32'(in_run), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
